// File: rtl/lnrv_exu_wbck_pkg.sv
// ---------------------------------------------------------------------------
// lnrv_exu_wbck_pkg
// Shared constants for the EXU writeback path: number of execution units,
// their bit positions in the one-hot unit select, and the register-file
// index width. The dispatcher encodes its unit select with the same bits.
// ---------------------------------------------------------------------------
package lnrv_exu_wbck_pkg;

   localparam int EXU_UNIT_NUM  = 6;
   localparam int EXU_UNIT_RGLR = 0;
   localparam int EXU_UNIT_LSU  = 1;
   localparam int EXU_UNIT_BRCH = 2;
   localparam int EXU_UNIT_CSR  = 3;
   localparam int EXU_UNIT_SYS  = 4;
   localparam int EXU_UNIT_MDV  = 5;
   localparam int RF_IDX_WIDTH  = 5;

   // One bit per execution unit, one-hot when it names a single op owner.
   typedef logic [EXU_UNIT_NUM-1:0] unit_sel_t;

endpackage

// File: rtl/lnrv_exu_wbck_if.sv
// ---------------------------------------------------------------------------
// lnrv_exu_wbck_if
// Bundle of every signal that crosses the writeback block boundary:
//   dispatch side : disp_hsked, disp_sel, ord_full
//   unit results  : src_wbck_vld/rdy/wen/idx/data (per unit, packed)
//   register file : wbck_vld/rdy/wen/idx/data, wbck_idle
// slave  : the writeback block itself
// master : the surroundings (dispatcher, units, register file)
// ---------------------------------------------------------------------------
interface lnrv_exu_wbck_if #(
   parameter int XLEN = 32
);
   import lnrv_exu_wbck_pkg::*;

   logic                                  disp_hsked;
   unit_sel_t                             disp_sel;
   logic                                  ord_full;
   unit_sel_t                             src_wbck_vld;
   unit_sel_t                             src_wbck_rdy;
   unit_sel_t                             src_wbck_wen;
   logic [EXU_UNIT_NUM*RF_IDX_WIDTH-1:0]  src_wbck_idx;
   logic [EXU_UNIT_NUM*XLEN-1:0]          src_wbck_data;
   logic                                  wbck_vld;
   logic                                  wbck_rdy;
   logic                                  wbck_wen;
   logic [RF_IDX_WIDTH-1:0]               wbck_idx;
   logic [XLEN-1:0]                       wbck_data;
   logic                                  wbck_idle;

   modport master (
      output disp_hsked, disp_sel, src_wbck_vld, src_wbck_wen, src_wbck_idx,
             src_wbck_data, wbck_rdy,
      input  ord_full, src_wbck_rdy, wbck_vld, wbck_wen, wbck_idx, wbck_data,
             wbck_idle
   );

   modport slave (
      input  disp_hsked, disp_sel, src_wbck_vld, src_wbck_wen, src_wbck_idx,
             src_wbck_data, wbck_rdy,
      output ord_full, src_wbck_rdy, wbck_vld, wbck_wen, wbck_idx, wbck_data,
             wbck_idle
   );

endinterface

// File: rtl/lnrv_exu_wbck_ofifo.sv
// ---------------------------------------------------------------------------
// lnrv_exu_wbck_ofifo
// Order FIFO: ORD_DEPTH entries of one-hot unit select, recording dispatch
// order. Pointers wrap by explicit compare so the depth need not be a power
// of two.
// Ports: clk, rst_n (async low), push/push_sel, pop, head (oldest entry),
//        full, empty.
// ---------------------------------------------------------------------------
module lnrv_exu_wbck_ofifo
   import lnrv_exu_wbck_pkg::*;
#(
   parameter int ORD_DEPTH = 4,
   parameter int ORD_PTR_W = 2
) (
   input  logic      clk,
   input  logic      rst_n,
   input  logic      push,
   input  unit_sel_t push_sel,
   input  logic      pop,
   output unit_sel_t head,
   output logic      full,
   output logic      empty
);

   localparam logic [ORD_PTR_W-1:0] PTR_LAST = ORD_PTR_W'(ORD_DEPTH - 1);
   localparam logic [ORD_PTR_W:0]   CNT_FULL = (ORD_PTR_W + 1)'(ORD_DEPTH);

   unit_sel_t              mem [ORD_DEPTH];
   logic [ORD_PTR_W-1:0]   wr_ptr;
   logic [ORD_PTR_W-1:0]   rd_ptr;
   logic [ORD_PTR_W:0]     count;
   logic                   wr_en;
   logic                   rd_en;

   // A push while full is dropped outright; pop never relieves full in the
   // same cycle because full comes from the registered count.
   assign wr_en = push & ~full;
   assign rd_en = pop & ~empty;
   assign full  = (count == CNT_FULL);
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   // Entry storage has no reset; contents are only read when count > 0.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= push_sel;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         case ({wr_en, rd_en})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
      !(push && full));

   a_head_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      !empty |-> $onehot(head));

endmodule

// File: rtl/lnrv_exu_wbck.sv
// ---------------------------------------------------------------------------
// lnrv_exu_wbck
// EXU return path. Every dispatched op records its unit in the order FIFO;
// only the unit at the FIFO head is granted, so results reach the register
// file in dispatch order no matter how long each unit takes. The accepted
// result lands in a single output register one cycle later.
// Ports: clk, rst_n (async low), bus (lnrv_exu_wbck_if.slave) carrying the
//        dispatch, per-unit result and register-file writeback signals.
// ---------------------------------------------------------------------------
module lnrv_exu_wbck
   import lnrv_exu_wbck_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int ORD_DEPTH = 4,
   parameter int ORD_PTR_W = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   lnrv_exu_wbck_if.slave     bus
);

   unit_sel_t               head;
   unit_sel_t               src_rdy;
   logic                    ord_empty;
   logic                    ord_full;
   logic                    push;
   logic                    accept;
   logic                    out_free;
   logic                    sel_wen;
   logic [RF_IDX_WIDTH-1:0] sel_idx;
   logic [XLEN-1:0]         sel_data;

   logic                    wbck_vld_q;
   logic                    wbck_wen_q;
   logic [RF_IDX_WIDTH-1:0] wbck_idx_q;
   logic [XLEN-1:0]         wbck_data_q;

   assign push = bus.disp_hsked & (|bus.disp_sel);

   lnrv_exu_wbck_ofifo #(
      .ORD_DEPTH (ORD_DEPTH),
      .ORD_PTR_W (ORD_PTR_W)
   ) u_ofifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .push_sel (bus.disp_sel),
      .pop      (accept),
      .head     (head),
      .full     (ord_full),
      .empty    (ord_empty)
   );

   // The output slot can take a new result when it is empty or being drained
   // this cycle, which gives one writeback per cycle under wbck_rdy=1.
   assign out_free = ~wbck_vld_q | bus.wbck_rdy;
   assign src_rdy  = (ord_empty | ~out_free) ? '0 : head;
   assign accept   = |(bus.src_wbck_vld & src_rdy);

   // Head is one-hot, so an AND-OR mux picks the granted unit's result.
   always_comb begin
      sel_wen  = 1'b0;
      sel_idx  = '0;
      sel_data = '0;
      for (int i = 0; i < EXU_UNIT_NUM; i++) begin
         if (head[i]) begin
            sel_wen  = sel_wen  | bus.src_wbck_wen[i];
            sel_idx  = sel_idx  | bus.src_wbck_idx[RF_IDX_WIDTH*i +: RF_IDX_WIDTH];
            sel_data = sel_data | bus.src_wbck_data[XLEN*i +: XLEN];
         end
      end
   end

   // idx/data pass through even when wen=0; the register file qualifies
   // with wbck_wen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wbck_vld_q  <= 1'b0;
         wbck_wen_q  <= 1'b0;
         wbck_idx_q  <= '0;
         wbck_data_q <= '0;
      end else if (accept) begin
         wbck_vld_q  <= 1'b1;
         wbck_wen_q  <= sel_wen;
         wbck_idx_q  <= sel_idx;
         wbck_data_q <= sel_data;
      end else if (bus.wbck_rdy) begin
         wbck_vld_q  <= 1'b0;
      end
   end

   assign bus.ord_full     = ord_full;
   assign bus.src_wbck_rdy = src_rdy;
   assign bus.wbck_vld     = wbck_vld_q;
   assign bus.wbck_wen     = wbck_wen_q;
   assign bus.wbck_idx     = wbck_idx_q;
   assign bus.wbck_data    = wbck_data_q;
   assign bus.wbck_idle    = ord_empty & ~wbck_vld_q;

endmodule

// File: tb/tb_lnrv_exu_wbck.sv
// ---------------------------------------------------------------------------
// tb_lnrv_exu_wbck
// Bench for the EXU writeback block. The bench plays dispatcher, the six
// units and the register file. Its reference keeps the dispatch order as a
// queue of unit numbers and each unit's outstanding results as a queue; the
// granted unit is whoever is oldest, and the writeback slot holds whatever
// was last taken from that oldest unit.
// ---------------------------------------------------------------------------
module tb_lnrv_exu_wbck;
   import lnrv_exu_wbck_pkg::*;

   localparam int XLEN  = 32;
   localparam int DEPTH = 4;

   typedef struct {
      bit        wen;
      bit [4:0]  idx;
      bit [31:0] data;
   } res_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   lnrv_exu_wbck_if #(.XLEN(XLEN)) wb_if ();

   lnrv_exu_wbck #(
      .XLEN      (XLEN),
      .ORD_DEPTH (DEPTH),
      .ORD_PTR_W (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (wb_if)
   );

   // reference state
   int       ordq[$];
   res_t     uq[6][$];
   bit [5:0] held;
   bit       mvld;
   res_t     mout;
   res_t     nres;

   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int sel2unit(bit [5:0] s);
      for (int i = 0; i < 6; i++) if (s[i]) return i;
      return -1;
   endfunction

   function automatic res_t rand_res();
      res_t r;
      r.wen  = 1'($urandom_range(0, 1));
      r.idx  = 5'($urandom_range(0, 31));
      r.data = $urandom;
      return r;
   endfunction

   // Each unit presents the oldest of its outstanding results; once raised,
   // vld stays up (with stable payload) until the result is taken.
   task automatic drive_units(bit [5:0] raise);
      for (int u = 0; u < 6; u++) begin
         if (uq[u].size() > 0 && (held[u] || raise[u])) begin
            held[u] = 1'b1;
            wb_if.src_wbck_vld[u]         = 1'b1;
            wb_if.src_wbck_wen[u]         = uq[u][0].wen;
            wb_if.src_wbck_idx[5*u +: 5]  = uq[u][0].idx;
            wb_if.src_wbck_data[32*u +: 32] = uq[u][0].data;
         end else begin
            wb_if.src_wbck_vld[u]         = 1'b0;
            wb_if.src_wbck_wen[u]         = 1'($urandom_range(0, 1));
            wb_if.src_wbck_idx[5*u +: 5]  = 5'($urandom_range(0, 31));
            wb_if.src_wbck_data[32*u +: 32] = $urandom;
         end
      end
   endtask

   task automatic disp_op(int u, res_t r);
      wb_if.disp_hsked = 1'b1;
      wb_if.disp_sel   = 6'(1 << u);
      nres             = r;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
      wb_if.disp_hsked = 1'b0;
      wb_if.disp_sel   = 6'($urandom_range(0, 63));
      wb_if.wbck_rdy   = 1'b1;
      drive_units(6'b0);
   endtask

   // Compare all outputs against the reference, then advance the reference
   // by what the coming clock edge will do.
   task automatic cmp_cycle();
      bit [5:0] exp_rdy;
      int       u;
      @(negedge clk);
      exp_rdy = (ordq.size() > 0 && (!mvld || wb_if.wbck_rdy)) ? 6'(1 << ordq[0]) : 6'b0;
      chk("src_wbck_rdy", wb_if.src_wbck_rdy, exp_rdy);
      chk("ord_full", wb_if.ord_full, ordq.size() == DEPTH);
      chk("wbck_vld", wb_if.wbck_vld, mvld);
      chk("wbck_idle", wb_if.wbck_idle, ordq.size() == 0 && !mvld);
      if (mvld) begin
         chk("wbck_wen", wb_if.wbck_wen, mout.wen);
         chk("wbck_idx", wb_if.wbck_idx, mout.idx);
         chk("wbck_data", wb_if.wbck_data, mout.data);
      end
      if ((exp_rdy & wb_if.src_wbck_vld) != 0) begin
         u       = ordq.pop_front();
         mout    = uq[u].pop_front();
         mvld    = 1'b1;
         held[u] = 1'b0;
      end else if (wb_if.wbck_rdy) begin
         mvld = 1'b0;
      end
      if (wb_if.disp_hsked && wb_if.disp_sel != 0) begin
         u = sel2unit(wb_if.disp_sel);
         ordq.push_back(u);
         uq[u].push_back(nres);
      end
   endtask

   task automatic clear_model();
      ordq.delete();
      for (int u = 0; u < 6; u++) uq[u].delete();
      held = '0;
      mvld = 1'b0;
   endtask

   initial begin
      res_t ra, rb;
      wb_if.disp_hsked    = 1'b0;
      wb_if.disp_sel      = '0;
      wb_if.src_wbck_vld  = '0;
      wb_if.src_wbck_wen  = '0;
      wb_if.src_wbck_idx  = '0;
      wb_if.src_wbck_data = '0;
      wb_if.wbck_rdy      = 1'b1;
      clear_model();

      // ---- reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst wbck_vld", wb_if.wbck_vld, 1'b0);
      chk("rst src_rdy", wb_if.src_wbck_rdy, 6'b0);
      chk("rst ord_full", wb_if.ord_full, 1'b0);
      chk("rst wbck_idle", wb_if.wbck_idle, 1'b1);
      chk("rst wbck_data", wb_if.wbck_data, 32'h0);
      chk("rst wbck_idx", wb_if.wbck_idx, 5'd0);

      // ---- single op through rglr
      next_cycle();
      ra = '{1'b1, 5'd5, 32'h1234};
      disp_op(EXU_UNIT_RGLR, ra);
      cmp_cycle();
      next_cycle();
      drive_units(6'b000001);
      cmp_cycle();
      chk("single rglr rdy", wb_if.src_wbck_rdy, 6'b000001);
      next_cycle();
      cmp_cycle();
      chk("single wbck_vld", wb_if.wbck_vld, 1'b1);
      chk("single wbck_idx", wb_if.wbck_idx, 5'd5);
      chk("single wbck_data", wb_if.wbck_data, 32'h1234);
      next_cycle();
      cmp_cycle();
      chk("single idle after rdy", wb_if.wbck_idle, 1'b1);

      // ---- out-of-order completion: mdv dispatched first, rglr finishes first
      next_cycle();
      ra = '{1'b1, 5'd7, 32'hAAAA_0001};
      disp_op(EXU_UNIT_MDV, ra);
      cmp_cycle();
      next_cycle();
      rb = '{1'b1, 5'd9, 32'hBBBB_0002};
      disp_op(EXU_UNIT_RGLR, rb);
      cmp_cycle();
      repeat (3) begin
         next_cycle();
         drive_units(6'b000001);
         cmp_cycle();
         chk("ooo rglr blocked", wb_if.src_wbck_rdy, 6'b100000);
      end
      next_cycle();
      drive_units(6'b100000);
      cmp_cycle();
      next_cycle();
      cmp_cycle();
      chk("ooo first is mdv", wb_if.wbck_data, 32'hAAAA_0001);
      chk("ooo rglr now granted", wb_if.src_wbck_rdy, 6'b000001);
      next_cycle();
      cmp_cycle();
      chk("ooo second is rglr", wb_if.wbck_data, 32'hBBBB_0002);
      chk("ooo second idx", wb_if.wbck_idx, 5'd9);
      next_cycle();
      cmp_cycle();

      // ---- fill to full, then push/pop pairs across the pointer wrap
      for (int i = 0; i < DEPTH; i++) begin
         next_cycle();
         disp_op(i, rand_res());
         cmp_cycle();
      end
      next_cycle();
      drive_units(6'b111111);
      cmp_cycle();
      chk("full after 4 pushes", wb_if.ord_full, 1'b1);
      chk("full head granted", wb_if.src_wbck_rdy, 6'b000001);
      for (int i = 0; i < 12; i++) begin
         next_cycle();
         if (ordq.size() < DEPTH) disp_op($urandom_range(0, 5), rand_res());
         drive_units(6'b111111);
         cmp_cycle();
      end
      repeat (8) begin
         next_cycle();
         drive_units(6'b111111);
         cmp_cycle();
      end

      // ---- back-pressure from the register file
      next_cycle();
      ra = '{1'b0, 5'd3, 32'hC0DE_0003};
      disp_op(EXU_UNIT_CSR, ra);
      cmp_cycle();
      next_cycle();
      rb = '{1'b1, 5'd4, 32'hD00D_0004};
      disp_op(EXU_UNIT_SYS, rb);
      drive_units(6'b001000);
      cmp_cycle();
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         wb_if.wbck_rdy = 1'b0;
         drive_units(6'b010000);
         cmp_cycle();
         chk("bp head held off", wb_if.src_wbck_rdy, 6'b0);
         chk("bp output holds", wb_if.wbck_data, 32'hC0DE_0003);
         chk("bp wen0 presented", wb_if.wbck_wen, 1'b0);
      end
      next_cycle();
      cmp_cycle();
      chk("bp released grant", wb_if.src_wbck_rdy, 6'b010000);
      next_cycle();
      cmp_cycle();
      chk("bp no bubble", wb_if.wbck_data, 32'hD00D_0004);
      chk("bp no bubble vld", wb_if.wbck_vld, 1'b1);
      next_cycle();
      cmp_cycle();

      // ---- reset in the middle of traffic
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         disp_op(i, rand_res());
         if (i == 2) drive_units(6'b000001);
         cmp_cycle();
      end
      next_cycle();
      wb_if.wbck_rdy = 1'b0;
      cmp_cycle();
      chk("pre-reset wbck_vld", wb_if.wbck_vld, 1'b1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async rst wbck_vld", wb_if.wbck_vld, 1'b0);
      chk("async rst ord_full", wb_if.ord_full, 1'b0);
      chk("async rst idle", wb_if.wbck_idle, 1'b1);
      chk("async rst src_rdy", wb_if.src_wbck_rdy, 6'b0);
      clear_model();
      wb_if.disp_hsked = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
      wb_if.src_wbck_vld = 6'b111111;
      cmp_cycle();
      chk("post-reset no grant", wb_if.src_wbck_rdy, 6'b0);

      // ---- randomized traffic
      for (int c = 0; c < 3000; c++) begin
         next_cycle();
         wb_if.wbck_rdy = ($urandom_range(0, 3) != 0);
         if (ordq.size() < DEPTH && $urandom_range(0, 2) != 0)
            disp_op($urandom_range(0, 5), rand_res());
         else if ($urandom_range(0, 9) == 0) begin
            wb_if.disp_hsked = 1'b1;
            wb_if.disp_sel   = 6'b0;
         end
         drive_units(6'($urandom) & 6'($urandom));
         cmp_cycle();
      end

      // drain
      repeat (40) begin
         next_cycle();
         drive_units(6'b111111);
         cmp_cycle();
      end
      chk("final idle", wb_if.wbck_idle, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
